kinase_assay_sequencer: RTL and testbench



---
 rtl/kinase_assay_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_kinase_assay_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/kinase_assay_sequencer.sv
// rtl/kinase_assay_sequencer.sv - kinase assay recipe sequencer (valves + pumps); option macro KINASE_SEQ_FLUSH_EN
module kinase_assay_sequencer #(
    parameter int PHASE_DIV = 4,
    parameter int LOAD_PER  = 8,
    parameter int MIX_PER   = 16,
    parameter int INC_PER   = 64,
    parameter int ELUTE_PER = 8,
    parameter int FLUSH_PER = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state,
    output logic [12:0] ctrl_a,
    output logic [3:0]  ctrl_s,
    output logic [2:0]  pump_a,
    output logic [1:0]  pump_b
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_A   = 3'd1,
        S_LOAD_B   = 3'd2,
        S_MIX      = 3'd3,
        S_INCUBATE = 3'd4,
        S_ELUTE    = 3'd5,
        S_FLUSH    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam int DIV_W = $clog2(PHASE_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PHASE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // Zero-length segments run one period, hence the clamp on the last index.
    localparam logic [15:0] LOAD_LAST  = (LOAD_PER  > 1) ? 16'(LOAD_PER  - 1) : 16'd0;
    localparam logic [15:0] MIX_LAST   = (MIX_PER   > 1) ? 16'(MIX_PER   - 1) : 16'd0;
    localparam logic [15:0] INC_LAST   = (INC_PER   > 1) ? 16'(INC_PER   - 1) : 16'd0;
    localparam logic [15:0] ELUTE_LAST = (ELUTE_PER > 1) ? 16'(ELUTE_PER - 1) : 16'd0;
    localparam logic [15:0] FLUSH_LAST = (FLUSH_PER > 1) ? 16'(FLUSH_PER - 1) : 16'd0;

`ifdef KINASE_SEQ_FLUSH_EN
    localparam state_t ABORT_TARGET = S_FLUSH;
    localparam state_t ELUTE_NEXT   = S_FLUSH;
`else
    localparam state_t ABORT_TARGET = S_IDLE;
    localparam state_t ELUTE_NEXT   = S_DONE;
`endif

    state_t           state_q, state_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [2:0]       phase_q, phase_n;
    logic [15:0]      per_q, per_n;
    logic [15:0]      per_last;
    logic             phase_end, seg_end, timed;

    always_comb begin
        per_last = 16'd0;
        case (state_q)
            S_LOAD_A, S_LOAD_B: per_last = LOAD_LAST;
            S_MIX:              per_last = MIX_LAST;
            S_INCUBATE:         per_last = INC_LAST;
            S_ELUTE:            per_last = ELUTE_LAST;
            S_FLUSH:            per_last = FLUSH_LAST;
            default:            per_last = 16'd0;
        endcase
    end

    always_comb begin
        state_n   = state_q;
        div_n     = div_q;
        phase_n   = phase_q;
        per_n     = per_q;
        timed     = (state_q != S_IDLE) && (state_q != S_DONE);
        phase_end = (div_q == DIV_LAST);
        seg_end   = phase_end && (phase_q == 3'd5) && (per_q == per_last);

        if (timed) begin
            if (phase_end) begin
                div_n = '0;
                if (phase_q == 3'd5) begin
                    phase_n = 3'd0;
                    per_n   = per_q + 16'd1;
                end else begin
                    phase_n = phase_q + 3'd1;
                end
            end else begin
                div_n = div_q + DIV_ONE;
            end
        end

        case (state_q)
            S_IDLE:     if (start && !abort) state_n = S_LOAD_A;
            S_LOAD_A:   if (seg_end) state_n = S_LOAD_B;
            S_LOAD_B:   if (seg_end) state_n = S_MIX;
            S_MIX:      if (seg_end) state_n = S_INCUBATE;
            S_INCUBATE: if (seg_end) state_n = S_ELUTE;
            S_ELUTE:    if (seg_end) state_n = ELUTE_NEXT;
            S_FLUSH:    if (seg_end) state_n = S_IDLE;
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase

        // FLUSH is the safe state, so an abort there just lets it finish.
        if (abort && (state_q != S_IDLE) && (state_q != S_FLUSH))
            state_n = ABORT_TARGET;

        if (state_n != state_q) begin
            div_n   = '0;
            phase_n = 3'd0;
            per_n   = 16'd0;
        end
    end

    logic [12:0] ctrl_a_n;
    logic [3:0]  ctrl_s_n;
    logic [2:0]  pump_a_n;
    logic [1:0]  pump_b_n;

    always_comb begin
        ctrl_a_n = 13'h1FFF;
        ctrl_s_n = 4'hF;
        pump_a_n = 3'b111;
        pump_b_n = 2'b11;
        case (state_n)
            S_LOAD_A: begin ctrl_a_n = 13'h1F7E; ctrl_s_n = 4'hE; end
            S_LOAD_B: begin ctrl_a_n = 13'h1EFD; ctrl_s_n = 4'hD; end
            S_MIX:    begin ctrl_a_n = 13'h007F; ctrl_s_n = 4'hF; end
            S_ELUTE:  begin ctrl_a_n = 13'h0FF3; ctrl_s_n = 4'hB; end
            S_FLUSH:  begin ctrl_a_n = 13'h1F83; ctrl_s_n = 4'h0; end
            default:  begin ctrl_a_n = 13'h1FFF; ctrl_s_n = 4'hF; end
        endcase
        if ((state_n == S_LOAD_A) || (state_n == S_LOAD_B) ||
            (state_n == S_ELUTE)  || (state_n == S_FLUSH)) begin
            case (phase_n)
                3'd0:    pump_a_n = 3'b011;
                3'd1:    pump_a_n = 3'b001;
                3'd2:    pump_a_n = 3'b101;
                3'd3:    pump_a_n = 3'b100;
                3'd4:    pump_a_n = 3'b110;
                3'd5:    pump_a_n = 3'b010;
                default: pump_a_n = 3'b111;
            endcase
        end
        if (state_n == S_MIX)
            pump_b_n = phase_n[0] ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            phase_q <= 3'd0;
            per_q   <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ctrl_a  <= 13'h1FFF;
            ctrl_s  <= 4'hF;
            pump_a  <= 3'b111;
            pump_b  <= 2'b11;
        end else begin
            state_q <= state_n;
            div_q   <= div_n;
            phase_q <= phase_n;
            per_q   <= per_n;
            busy    <= (state_n != S_IDLE);
            done    <= (state_n == S_DONE);
            ctrl_a  <= ctrl_a_n;
            ctrl_s  <= ctrl_s_n;
            pump_a  <= pump_a_n;
            pump_b  <= pump_b_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_kinase_assay_sequencer.sv
// tb/tb_kinase_assay_sequencer.sv - scoreboard bench for kinase_assay_sequencer
module tb_kinase_assay_sequencer;

    localparam int PD = 2;
    localparam int L  = 6 * PD;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [2:0]  state;
    logic [12:0] ctrl_a;
    logic [3:0]  ctrl_s;
    logic [2:0]  pump_a;
    logic [1:0]  pump_b;
    logic [26:0] act;

    kinase_assay_sequencer #(
        .PHASE_DIV(PD), .LOAD_PER(1), .MIX_PER(1), .INC_PER(1),
        .ELUTE_PER(1), .FLUSH_PER(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .state(state),
        .ctrl_a(ctrl_a), .ctrl_s(ctrl_s), .pump_a(pump_a), .pump_b(pump_b)
    );

    always #5 clk = ~clk;

    assign act = {state, busy, done, ctrl_a, ctrl_s, pump_a, pump_b};

    typedef struct {
        int          cyc;
        logic [26:0] v;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for the k-th cycle spent in state s, straight from the recipe tables.
    function automatic logic [26:0] expv(input logic [2:0] s, input int k);
        logic [12:0] ca;
        logic [3:0]  cs;
        logic [2:0]  pa;
        logic [1:0]  pb;
        int          p;
        p  = (k / PD) % 6;
        ca = 13'h1FFF;
        cs = 4'hF;
        case (s)
            3'd1: begin ca = 13'h1F7E; cs = 4'hE; end
            3'd2: begin ca = 13'h1EFD; cs = 4'hD; end
            3'd3: begin ca = 13'h007F; cs = 4'hF; end
            3'd5: begin ca = 13'h0FF3; cs = 4'hB; end
            3'd6: begin ca = 13'h1F83; cs = 4'h0; end
            default: begin ca = 13'h1FFF; cs = 4'hF; end
        endcase
        pa = 3'b111;
        if (s == 3'd1 || s == 3'd2 || s == 3'd5 || s == 3'd6) begin
            case (p)
                0: pa = 3'b011;
                1: pa = 3'b001;
                2: pa = 3'b101;
                3: pa = 3'b100;
                4: pa = 3'b110;
                default: pa = 3'b010;
            endcase
        end
        pb = 2'b11;
        if (s == 3'd3) pb = (p % 2 == 0) ? 2'b10 : 2'b01;
        return {s, (s != 3'd0), (s == 3'd7), ca, cs, pa, pb};
    endfunction

    initial forever begin
        @(negedge clk or negedge rst_n);
        if (clk) begin
            #1;
            checks++;
            if (act !== expv(3'd0, 0)) begin
                errors++;
                $display("FAIL async_reset t=%0t: got %h required %h", $time, act, expv(3'd0, 0));
            end
        end else begin
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                mon_e = q.pop_front();
                checks++;
                if (mon_e.cyc < cyc) begin
                    errors++;
                    $display("FAIL stale cyc=%0d: entry for cycle %0d got no sample, required %h",
                             cyc, mon_e.cyc, mon_e.v);
                end else if (act !== mon_e.v) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d {st,busy,done,ca,cs,pa,pb}: got %h required %h",
                             cyc, act, mon_e.v);
                end
            end
        end
    end

    task automatic push_run(input int c, input logic [2:0] s, input int len);
        for (int k = 0; k < len; k++) begin
            exp_t e;
            e.cyc = c + k;
            e.v   = expv(s, k);
            q.push_back(e);
        end
    endtask

    task automatic push_recipe(input int c);
        int n;
`ifdef KINASE_SEQ_FLUSH_EN
        n = 6;
`else
        n = 5;
`endif
        for (int s = 1; s <= n; s++) push_run(c + 1 + (s - 1) * L, 3'(s), L);
        push_run(c + 1 + n * L, 3'd7, 1);
        push_run(c + 2 + n * L, 3'd0, 2);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            $display("FAIL drain: %0d entries left, required 0", q.size());
            $fatal(1);
        end
        @(negedge clk);
    endtask

    int c;

    initial begin
        @(negedge clk);
        push_run(cyc + 1, 3'd0, 3);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        // Full recipe
        c = cyc;
        push_recipe(c);
        pulse_start();
        drain();

        // Abort in the third MIX cycle, then a second abort inside FLUSH
        c = cyc;
        push_run(c + 1, 3'd1, L);
        push_run(c + 1 + L, 3'd2, L);
        push_run(c + 1 + 2 * L, 3'd3, 3);
`ifdef KINASE_SEQ_FLUSH_EN
        push_run(c + 4 + 2 * L, 3'd6, L);
        push_run(c + 4 + 3 * L, 3'd0, 2);
`else
        push_run(c + 4 + 2 * L, 3'd0, 2);
`endif
        pulse_start();
        wait_until(c + 3 + 2 * L);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`ifdef KINASE_SEQ_FLUSH_EN
        wait_until(c + 6 + 2 * L);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif
        drain();

        // start and abort together in IDLE
        c = cyc;
        push_run(c + 1, 3'd0, 4);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        drain();

        // start pulsed during LOAD_B must not disturb timing
        c = cyc;
        push_recipe(c);
        pulse_start();
        wait_until(c + 4 + L);
        pulse_start();
        drain();

        // Asynchronous reset in the middle of INCUBATE, then a clean rerun
        c = cyc;
        push_run(c + 1, 3'd1, L);
        push_run(c + 1 + L, 3'd2, L);
        push_run(c + 1 + 2 * L, 3'd3, L);
        push_run(c + 1 + 3 * L, 3'd4, 5);
        pulse_start();
        wait_until(c + 5 + 3 * L);
        push_run(c + 6 + 3 * L, 3'd0, 3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        c = cyc;
        push_recipe(c);
        pulse_start();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
